alu_iter: RTL
=============

# alu_iter

Sequential execution unit at the consuming end of the ALU-control interface: accepts the 3-bit ALU control code produced by the ALU decoder plus two operands, and returns a registered result with a done pulse. Single-cycle ops finish in one cycle. Shifts iterate one bit position per cycle, so the core can run at a higher clock without a barrel shifter. Sits in the execute stage of the multi-cycle datapath, between the operand muxes and the writeback mux.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only when busy_o=0
- alucontrol_i  input  3  op: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed), 110 sll, 111 srl; 100 illegal
- srca_i  input  WIDTH  operand A / value to shift
- srcb_i  input  WIDTH  operand B; shifts use srcb_i[SHW-1:0] only
- busy_o  output  1  high from the cycle after an accepted shift start until its done cycle
- done_o  output  1  one-cycle pulse, result valid
- result_o  output  WIDTH  registered result, held until the next done
- zero_o  output  1  registered (result_o == 0), updated with result_o
- illegal_o  output  1  pulses with done_o when the op was 100

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with start_i=1 and a non-shift op: compute the result combinationally and register it. Go to DONE.
- IDLE with start_i=1 and a shift op: latch srca_i into the accumulator, latch shamt and the direction. If shamt=0, go to DONE with result=srca_i. Otherwise go to SHIFT.
- SHIFT: each cycle shift the accumulator by 1 (left, or logical right with zero fill) and decrement shamt. When shamt reaches 1, register the final value and go to DONE.
- DONE: assert done_o for exactly one cycle, then return to IDLE. start_i in DONE is ignored.
- Arithmetic:
  - add/sub are modulo 2^WIDTH; carry is discarded.
  - slt compares signed two's complement; result is {WIDTH-1 zeros, lt}.
- Illegal op 100: result 0, zero_o=1, illegal_o=1, one-cycle latency.
- start_i while busy_o=1 or in DONE is dropped. It is not queued.
- Operand inputs are sampled only at the accept edge. Later changes have no effect.

## Timing
- Reset values: state IDLE, busy_o=0, done_o=0, result_o=0, zero_o=1, illegal_o=0, accumulator and count cleared.
- Reset mid-shift: abort on the next edge, return to IDLE, no done_o.
- Latency, accept edge to done_o high:
  - non-shift ops: 1 cycle
  - shift with shamt=0: 1 cycle
  - shift with shamt=n: n+1 cycles
- busy_o is high in SHIFT only. It is not high in DONE.
- Maximum throughput is one op per 2 cycles (IDLE→DONE→IDLE).
- Shift by WIDTH-1 takes WIDTH cycles and yields the MSB or LSB moved to the opposite end.

## Configuration
- ALU_ITER_FAST_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter and follow the non-shift path. SHIFT state is unused, busy_o stays 0, all ops have 1-cycle latency.
- Undefined: iterative shifting as described above.
- Port list is identical in both builds.

## Structure
- Shared package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t with ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL; the ALU decoder imports the same typedef
  - typedef enum alu_iter_state_t {IDLE, SHIFT, DONE}
  - constant ALU_OP_ILLEGAL = 3'b100
- One sub-module, alu_basic: purely combinational add/sub/and/or/slt on WIDTH bits. The FSM and shifter stay in alu_iter.

## Test plan
- Reset, then idle: result_o=0, zero_o=1, done_o=0, busy_o=0. Assert rst_i during a 20-cycle shift: no done_o, IDLE next cycle.
- add 0x7FFFFFFF+1 → 0x80000000 after 1 cycle. sub 5−5 → 0 with zero_o=1. slt 0xFFFFFFFF vs 1 → 1. and/or 0xF0F0F0F0 with 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0.
- sll 0x00000001 by 31 → 0x80000000, done 32 cycles after accept, busy_o high for 31 cycles. srl 0x80000000 by 4 → 0x08000000 after 5 cycles.
- Shift by 0 (srcb=0x20, only low 5 bits used) → result=srca, 1-cycle latency. start_i pulsed during SHIFT and during DONE → dropped, exactly one done_o per accepted start.
- Op 100 → result 0, illegal_o and done_o together for one cycle. Back-to-back starts every cycle → accepted every other cycle.
- Rebuild with ALU_ITER_FAST_SHIFT_EN: sll 1 by 31 → 0x80000000 in 1 cycle, busy_o never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, iterative-unit FSM states and helpers
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_iter_state_t;
  localparam logic [2:0] ALU_OP_ILLEGAL = 3'b100;
  function automatic logic is_shift(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
endpackage

// File: rtl/alu_basic.sv
// alu_basic: combinational add/sub/and/or/slt; any other op yields zero
module alu_basic
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  // single-cycle result select; shifts and the illegal code fall through to 0
  always_comb begin
    y_o = op_i == ALU_ADD ? a_i + b_i :
          op_i == ALU_SUB ? a_i - b_i :
          op_i == ALU_AND ? a_i & b_i :
          op_i == ALU_OR  ? a_i | b_i :
          op_i == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)} :
          '0;
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: registered ALU with one-bit-per-cycle shifter; ALU_ITER_FAST_SHIFT_EN selects a barrel shifter instead
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       alucontrol_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);
  localparam int SHW = $clog2(WIDTH);
  alu_iter_state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d, basic_y, fast_y, acc_step;
  logic [SHW-1:0] cnt_q, cnt_d, shamt;
  logic dir_q, dir_d, zero_q, zero_d, ill_q, ill_d, iter_shift, accept;
  assign shamt = srcb_i[SHW-1:0];
  assign accept = state_q == IDLE && start_i;
  alu_basic #(.WIDTH(WIDTH)) u_basic (
    .op_i(alucontrol_i),
    .a_i(srca_i),
    .b_i(srcb_i),
    .y_o(basic_y)
  );
`ifdef ALU_ITER_FAST_SHIFT_EN
  assign iter_shift = 1'b0;
  assign fast_y = alucontrol_i == ALU_SLL ? srca_i << shamt :
                  alucontrol_i == ALU_SRL ? srca_i >> shamt : basic_y;
`else
  assign iter_shift = is_shift(alucontrol_i);
  assign fast_y = basic_y;
`endif
  assign acc_step = dir_q ? acc_q >> 1 : acc_q << 1;
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: zero-length shifts skip SHIFT, the last shift step lands in DONE
  always_comb begin
    state_d = state_q == IDLE  ? (start_i ? ((iter_shift && shamt != '0) ? SHIFT : DONE) : IDLE) :
              state_q == SHIFT ? (cnt_q == SHW'(1) ? DONE : SHIFT) :
              IDLE;
  end
  // outputs decoded from state; illegal only shows during the done pulse
  always_comb begin
    busy_o    = state_q == SHIFT;
    done_o    = state_q == DONE;
    illegal_o = done_o & ill_q;
    result_o  = result_q;
    zero_o    = zero_q;
  end
  // datapath next values: operands latched on accept, accumulator stepped in SHIFT
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    result_d = result_q;
    ill_d    = ill_q;
    if (accept) begin
      acc_d = srca_i;
      cnt_d = shamt;
      dir_d = alucontrol_i[0];
      if (!iter_shift || shamt == '0) begin
        result_d = iter_shift ? srca_i : fast_y;
        ill_d    = alucontrol_i == ALU_OP_ILLEGAL;
      end
    end else if (state_q == SHIFT) begin
      acc_d = acc_step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == SHW'(1)) begin
        result_d = acc_step;
        ill_d    = 1'b0;
      end
    end
    zero_d = result_d == '0;
  end
  // datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ill_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
    end
  end
endmodule
